posit_add_arbiter: RTL and testbench
====================================

POSIT_ADD_ARBITER -- requirements
Module: posit_add_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, posit word width.
REQ-002 SHALL have parameter LAT, default 4, fixed adder latency in cycles (1..15).
REQ-003 SHALL have parameter RES_DEPTH, default 4, per-port result buffer depth (power of 2, >=2).
REQ-004 SHALL have port ACLK  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port ARESET  in  1  synchronous active-high reset.
REQ-006 SHALL have ports s0_valid/s1_valid  in  1  operand pair offered by requester 0/1.
REQ-007 SHALL have ports s0_ready/s1_ready  out  1  operand pair accepted this cycle.
REQ-008 SHALL have ports s0_a, s0_b, s1_a, s1_b  in  N  operands.
REQ-009 SHALL have ports m0_valid/m1_valid  out  1  result available for requester 0/1.
REQ-010 SHALL have ports m0_ready/m1_ready  in  1  requester consumes result.
REQ-011 SHALL have ports m0_sum/m1_sum  out  N  result word.
REQ-012 SHALL have ports add_in_valid  out  1; add_a, add_b  out  N, driving the shared in-order non-stalling posit adder.
REQ-013 SHALL have ports add_out_valid  in  1; add_sum  in  N, adder output.
REQ-014 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-015 SHALL contain a state machine DRAIN -> RUN; DRAIN lasts exactly LAT+1 cycles after reset release, then RUN permanently until reset.
REQ-016 In DRAIN, s0_ready=s1_ready=0 and add_out_valid SHALL be ignored (stale in-flight results discarded, err unaffected).
REQ-017 In RUN, at most one sK_ready SHALL be high per cycle; sK_ready SHALL be combinational from sK_valid, credit and arbitration state.
REQ-018 Port K is eligible when sK_valid=1 and credit_K < RES_DEPTH, credit_K = in-flight + buffered results of port K.
REQ-019 Arbitration SHALL be round-robin: when both eligible, grant the port not granted last; last-grant pointer resets to 1 (port 0 wins first tie).
REQ-020 A single eligible port SHALL be granted immediately regardless of pointer; pointer updates only on a grant.
REQ-021 On grant, add_in_valid SHALL be 1 the next cycle with the registered operands; otherwise add_in_valid=0 and add_a/add_b hold.
REQ-022 Each issue SHALL push the port ID into a tag FIFO of depth >= LAT+2; each add_out_valid in RUN SHALL pop it and write add_sum into that port's result buffer.
REQ-023 add_out_valid in RUN with empty tag FIFO SHALL set err; the sum is dropped.
REQ-024 Result buffer write SHALL be visible as mK_valid=1 one cycle after add_out_valid; handshake-to-mK_valid latency = LAT+2 cycles.
REQ-025 mK_sum SHALL be the head of buffer K while mK_valid=1; popped when mK_valid&&mK_ready.
REQ-026 credit_K +1 on grant, -1 on pop; both same cycle -> unchanged; credits guarantee no buffer overflow.
REQ-027 Results per port SHALL be returned in issue order; ports are independent (backpressure on m0 SHALL NOT block port 1 beyond its own credit).

Reset
REQ-028 ARESET SHALL, at any time incl. mid-operation, clear all buffers, tag FIFO, credits, err; enter DRAIN; pointer=1.
REQ-029 Output reset values: s*_ready=0, m*_valid=0, m*_sum=0, add_in_valid=0, add_a=add_b=0, err=0.

Structure
REQ-030 Package posit_arb_pkg SHALL hold the state enum (DRAIN, RUN), port-ID tag type, and max-LAT constant.
REQ-031 One sub-module posit_res_fifo (synchronous FIFO, parameters WIDTH, DEPTH, count output) SHALL be instantiated for each result buffer and for the tag FIFO.

Verification (bench uses behavioural LAT-cycle posit adder, N=32, ES=2)
REQ-032 Reset, wait LAT+1 cycles; s0 offers 0x40000000+0x40000000 -> s0_ready that cycle, m0_valid after LAT+2 cycles with m0_sum=0x48000000.
REQ-033 Both ports valid every cycle, m*_ready=1 -> grants alternate 0,1,0,1; 8 results each, in order, none lost.
REQ-034 m0_ready=0, s0 streams -> s0_ready drops after exactly RES_DEPTH=4 grants; port 1 traffic continues; raising m0_ready drains 4 results and re-enables s0.
REQ-035 Pulse add_out_valid in RUN with nothing issued -> err=1 next cycle and stays 1 until ARESET.
REQ-036 Assert ARESET with 3 in flight -> all valid/ready low; stale add_out_valid pulses during DRAIN produce no m*_valid and err=0.

Source files
------------

// File: rtl/posit_arb_pkg.sv
// Shared types and constants for the two-port posit adder arbiter.
package posit_arb_pkg;

  // Largest supported adder latency; sizes the drain counter.
  localparam int MAX_LAT = 15;

  // Controller phase: flush stale adder results, then serve requests.
  typedef enum logic [0:0] {
    ST_DRAIN = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  // Identifies which requester an issued operation belongs to.
  typedef logic [0:0] port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/posit_res_fifo.sv
// Synchronous FIFO with registered storage; used for result buffers and the tag FIFO.
// DEPTH must be a power of two so the pointers wrap naturally.
module posit_res_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok_s, rd_ok_s;

  assign wr_ok_s = wr_en && (count_q != CW'(DEPTH));
  assign rd_ok_s = rd_en && (count_q != {CW{1'b0}});

  assign empty   = (count_q == {CW{1'b0}});
  assign count   = count_q;
  assign rd_data = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok_s) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Register FIFO state; reset empties the FIFO and clears storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/posit_add_arbiter.sv
// Two-requester round-robin front end for a shared, in-order, non-stalling
// posit adder. Each requester gets its own result buffer guarded by credits,
// and returning sums are steered back by a tag FIFO of issuing port IDs.
module posit_add_arbiter
  import posit_arb_pkg::*;
#(
  parameter int N         = 32,
  parameter int LAT       = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         s0_valid,
  output logic         s0_ready,
  input  logic [N-1:0] s0_a,
  input  logic [N-1:0] s0_b,
  input  logic         s1_valid,
  output logic         s1_ready,
  input  logic [N-1:0] s1_a,
  input  logic [N-1:0] s1_b,
  output logic         m0_valid,
  input  logic         m0_ready,
  output logic [N-1:0] m0_sum,
  output logic         m1_valid,
  input  logic         m1_ready,
  output logic [N-1:0] m1_sum,
  output logic         add_in_valid,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic         add_out_valid,
  input  logic [N-1:0] add_sum,
  output logic         err
);

  localparam int TAG_DEPTH = 2 ** $clog2(LAT + 2);
  localparam int CW        = $clog2(RES_DEPTH + 1);
  localparam int TCW       = $clog2(TAG_DEPTH + 1);
  localparam int DCW       = $clog2(MAX_LAT + 2);

  arb_state_e     state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  port_id_t       last_q, last_d;
  logic [CW-1:0]  credit0_q, credit0_d;
  logic [CW-1:0]  credit1_q, credit1_d;
  logic           add_in_valid_q, add_in_valid_d;
  logic [N-1:0]   add_a_q, add_a_d;
  logic [N-1:0]   add_b_q, add_b_d;
  logic           err_q, err_d;

  logic           run_s, elig0_s, elig1_s, grant0_s, grant1_s;
  logic           pop0_s, pop1_s, ret_s, ret_ok_s;
  port_id_t       tag_in_s, tag_head_s;
  logic           tag_empty_s, res0_empty_s, res1_empty_s;
  logic [TCW-1:0] tag_count_s;
  logic [CW-1:0]  res0_count_s, res1_count_s;
  logic           unused_count_s;

  assign run_s    = (state_q == ST_RUN);
  assign elig0_s  = run_s && s0_valid && (credit0_q < CW'(RES_DEPTH));
  assign elig1_s  = run_s && s1_valid && (credit1_q < CW'(RES_DEPTH));
  // On a tie the port that did not win last time is served.
  assign grant0_s = elig0_s && (!elig1_s || (last_q == PORT1));
  assign grant1_s = elig1_s && (!elig0_s || (last_q == PORT0));
  assign s0_ready = grant0_s;
  assign s1_ready = grant1_s;
  assign tag_in_s = grant1_s ? PORT1 : PORT0;

  // Adder returns are honoured only in RUN; while draining they are stale.
  assign ret_s    = add_out_valid && run_s;
  assign ret_ok_s = ret_s && !tag_empty_s;

  assign m0_valid = !res0_empty_s;
  assign m1_valid = !res1_empty_s;
  assign pop0_s   = m0_valid && m0_ready;
  assign pop1_s   = m1_valid && m1_ready;

  assign add_in_valid = add_in_valid_q;
  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign err          = err_q;

  // Occupancy counts are informational only; credits track buffer usage.
  assign unused_count_s = ^{tag_count_s, res0_count_s, res1_count_s};

  posit_res_fifo #(.WIDTH(1), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (grant0_s || grant1_s),
    .wr_data (tag_in_s),
    .rd_en   (ret_s),
    .rd_data (tag_head_s),
    .empty   (tag_empty_s),
    .count   (tag_count_s)
  );

  posit_res_fifo #(.WIDTH(N), .DEPTH(RES_DEPTH)) u_res0_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (ret_ok_s && (tag_head_s == PORT0)),
    .wr_data (add_sum),
    .rd_en   (pop0_s),
    .rd_data (m0_sum),
    .empty   (res0_empty_s),
    .count   (res0_count_s)
  );

  posit_res_fifo #(.WIDTH(N), .DEPTH(RES_DEPTH)) u_res1_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (ret_ok_s && (tag_head_s == PORT1)),
    .wr_data (add_sum),
    .rd_en   (pop1_s),
    .rd_data (m1_sum),
    .empty   (res1_empty_s),
    .count   (res1_count_s)
  );

  // Phase sequencing: hold DRAIN for LAT+1 cycles, then RUN until reset.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_DRAIN: begin
        if (drain_cnt_q == DCW'(LAT)) begin
          state_d = ST_RUN;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_DRAIN;
        drain_cnt_d = {DCW{1'b0}};
      end
    endcase
  end

  // Arbitration pointer, credits, adder issue registers and error flag.
  always_comb begin
    last_d         = last_q;
    add_in_valid_d = grant0_s || grant1_s;
    add_a_d        = add_a_q;
    add_b_d        = add_b_q;
    if (grant0_s) begin
      last_d  = PORT0;
      add_a_d = s0_a;
      add_b_d = s0_b;
    end else if (grant1_s) begin
      last_d  = PORT1;
      add_a_d = s1_a;
      add_b_d = s1_b;
    end else begin
      last_d = last_q;
    end
    case ({grant0_s, pop0_s})
      2'b10:   credit0_d = credit0_q + CW'(1);
      2'b01:   credit0_d = credit0_q - CW'(1);
      default: credit0_d = credit0_q;
    endcase
    case ({grant1_s, pop1_s})
      2'b10:   credit1_d = credit1_q + CW'(1);
      2'b01:   credit1_d = credit1_q - CW'(1);
      default: credit1_d = credit1_q;
    endcase
    err_d = err_q || (ret_s && tag_empty_s);
  end

  // Register all control state; reset returns to DRAIN with port 1 as last winner.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q        <= ST_DRAIN;
      drain_cnt_q    <= {DCW{1'b0}};
      last_q         <= PORT1;
      credit0_q      <= {CW{1'b0}};
      credit1_q      <= {CW{1'b0}};
      add_in_valid_q <= 1'b0;
      add_a_q        <= {N{1'b0}};
      add_b_q        <= {N{1'b0}};
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      last_q         <= last_d;
      credit0_q      <= credit0_d;
      credit1_q      <= credit1_d;
      add_in_valid_q <= add_in_valid_d;
      add_a_q        <= add_a_d;
      add_b_q        <= add_b_d;
      err_q          <= err_d;
    end
  end

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Scoreboard bench for posit_add_arbiter with a behavioural LAT-cycle posit
// adder (N=32, ES=2) restricted to positive integer-valued operands.
module tb_posit_add_arbiter;

  localparam int LAT = 4;
  localparam int RD  = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [31:0] s0_a, s0_b, s1_a, s1_b;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_sum, m1_sum;
  logic        add_in_valid, add_out_valid, err;
  logic [31:0] add_a, add_b, add_sum;

  bit          pv [LAT];
  bit   [31:0] ps [LAT];
  logic        inj;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int  ia0, ib0, ia1, ib1;
  bit  en0, en1, alt_chk, rnd_ready, hs0, hs1;
  int  g0cnt, g1cnt, lim0, lim1, last_g;

  posit_add_arbiter #(.N(32), .LAT(LAT), .RES_DEPTH(RD)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_a(s0_a), .s0_b(s0_b),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_a(s1_a), .s1_b(s1_b),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_sum(m0_sum),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_sum(m1_sum),
    .add_in_valid(add_in_valid), .add_a(add_a), .add_b(add_b),
    .add_out_valid(add_out_valid), .add_sum(add_sum), .err(err)
  );

  always #5 ACLK = ~ACLK;

  // Encode a positive integer as a posit<32,2>; exact for the small range used here.
  function automatic logic [31:0] enc_int(input int v);
    int scale, k, e, idx;
    logic [31:0] p;
    if (v <= 0) return 32'h0;
    scale = 0;
    for (int i = 0; i < 30; i++) if (v >= (1 << i)) scale = i;
    k = scale / 4;
    e = scale % 4;
    p = 32'h0;
    idx = 30;
    for (int i = 0; i <= k; i++) begin p[idx] = 1'b1; idx--; end
    idx--;
    p[idx] = e[1]; idx--;
    p[idx] = e[0]; idx--;
    for (int j = scale - 1; j >= 0; j--) begin p[idx] = v[j]; idx--; end
    return p;
  endfunction

  // Decode a positive integer-valued posit<32,2> back to its integer value.
  function automatic int dec_int(input logic [31:0] p);
    int m, idx, e, scale, v;
    if (p == 32'h0 || p[31] || !p[30]) return 0;
    m = 0;
    idx = 30;
    while (idx >= 0 && p[idx]) begin m++; idx--; end
    idx--;
    e = 0;
    if (idx >= 1) e = 2 * int'(p[idx]) + int'(p[idx-1]);
    idx -= 2;
    scale = 4 * (m - 1) + e;
    if (scale > 20) return 0;
    v = 1 << scale;
    for (int j = 1; j <= scale; j++) begin
      if (idx - j + 1 >= 0 && p[idx-j+1]) v += 1 << (scale - j);
    end
    return v;
  endfunction

  // Behavioural adder pipeline; keeps running through reset so stale results appear.
  always @(posedge ACLK) begin
    pv[0] <= add_in_valid;
    ps[0] <= add_in_valid ? enc_int(dec_int(add_a) + dec_int(add_b)) : 32'h0;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      ps[i] <= ps[i-1];
    end
  end
  assign add_out_valid = pv[LAT-1] | inj;
  assign add_sum       = ps[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: record expected sums at input handshakes, compare at output handshakes.
  always @(negedge ACLK) begin
    if (s0_valid && s0_ready) q0.push_back(enc_int(ia0 + ib0));
    if (s1_valid && s1_ready) q1.push_back(enc_int(ia1 + ib1));
    checks++;
    if (s0_ready && s1_ready) begin
      errors++;
      $display("FAIL both_ready: got 1,1 expected at most one at %0t", $time);
    end
    if (m0_valid && m0_ready) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL m0_unexpected: got %h expected no result", m0_sum);
      end else begin
        logic [31:0] e0;
        e0 = q0.pop_front();
        if (m0_sum !== e0) begin
          errors++;
          $display("FAIL m0_sum: got %h expected %h at %0t", m0_sum, e0, $time);
        end
      end
    end
    if (m1_valid && m1_ready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL m1_unexpected: got %h expected no result", m1_sum);
      end else begin
        logic [31:0] e1;
        e1 = q1.pop_front();
        if (m1_sum !== e1) begin
          errors++;
          $display("FAIL m1_sum: got %h expected %h at %0t", m1_sum, e1, $time);
        end
      end
    end
  end

  // One cycle: sample handshakes mid-cycle, then update stimulus just after the edge.
  task automatic step();
    int cur;
    @(negedge ACLK);
    hs0 = s0_valid && s0_ready;
    hs1 = s1_valid && s1_ready;
    if (hs0) g0cnt++;
    if (hs1) g1cnt++;
    if (alt_chk && (hs0 || hs1)) begin
      cur = hs1 ? 1 : 0;
      if (last_g >= 0) chk("rr_alternate", cur, 1 - last_g);
      last_g = cur;
    end
    @(posedge ACLK);
    #1;
    if (hs0 || !s0_valid) begin
      if (en0 && g0cnt < lim0) begin
        s0_valid = 1'b1;
        ia0 = $urandom_range(1, 255); ib0 = $urandom_range(1, 255);
        s0_a = enc_int(ia0); s0_b = enc_int(ib0);
      end else begin
        s0_valid = 1'b0;
      end
    end
    if (hs1 || !s1_valid) begin
      if (en1 && g1cnt < lim1) begin
        s1_valid = 1'b1;
        ia1 = $urandom_range(1, 255); ib1 = $urandom_range(1, 255);
        s1_a = enc_int(ia1); s1_b = enc_int(ib1);
      end else begin
        s1_valid = 1'b0;
      end
    end
    if (rnd_ready) begin
      m0_ready = 1'($urandom_range(0, 1));
      m1_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && !(q0.size() == 0 && q1.size() == 0 && !s0_valid && !s1_valid); i++)
      step();
    chk({name, "_q0_empty"}, q0.size(), 0);
    chk({name, "_q1_empty"}, q1.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1; inj = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_a = 32'h0; s0_b = 32'h0; s1_a = 32'h0; s1_b = 32'h0;
    m0_ready = 1'b1; m1_ready = 1'b1;
    en0 = 1'b0; en1 = 1'b0; alt_chk = 1'b0; rnd_ready = 1'b0;
    g0cnt = 0; g1cnt = 0; lim0 = 0; lim1 = 0; last_g = -1;
    ia0 = 0; ib0 = 0; ia1 = 0; ib1 = 0;
    repeat (3) step();
    #1;
    chk("rst_s0_ready", s0_ready, 0);   chk("rst_s1_ready", s1_ready, 0);
    chk("rst_m0_valid", m0_valid, 0);   chk("rst_m1_valid", m1_valid, 0);
    chk("rst_m0_sum", m0_sum, 0);       chk("rst_m1_sum", m1_sum, 0);
    chk("rst_add_in_valid", add_in_valid, 0);
    chk("rst_add_a", add_a, 0);         chk("rst_add_b", add_b, 0);
    chk("rst_err", err, 0);

    // Single directed add 1.0 + 1.0 right after the drain window.
    ARESET = 1'b0;
    s0_valid = 1'b1; ia0 = 1; ib0 = 1; s0_a = 32'h4000_0000; s0_b = 32'h4000_0000;
    for (int i = 0; i <= LAT; i++) begin
      #1; chk("drain_s0_ready", s0_ready, 0);
      step();
    end
    #1; chk("first_s0_ready", s0_ready, 1);
    step();
    for (int i = 1; i <= LAT + 1; i++) begin
      #1;
      if (i == 1) begin
        chk("issue_valid", add_in_valid, 1);
        chk("issue_a", add_a, 32'h4000_0000);
      end
      chk("lat_m0_valid_low", m0_valid, 0);
      step();
    end
    #1;
    chk("lat_m0_valid", m0_valid, 1);
    chk("lat_m0_sum", m0_sum, 32'h4800_0000);
    step();

    // Both ports saturating with free-flowing outputs: strict alternation.
    g0cnt = 0; g1cnt = 0; lim0 = 8; lim1 = 8; en0 = 1'b1; en1 = 1'b1;
    alt_chk = 1'b1; last_g = -1;
    for (int i = 0; i < 200 && (g0cnt < 8 || g1cnt < 8); i++) step();
    alt_chk = 1'b0;
    chk("alt_g0cnt", g0cnt, 8);
    chk("alt_g1cnt", g1cnt, 8);
    wait_drain("alt");

    // Backpressure on port 0 caps it at RD outstanding; port 1 keeps going.
    m0_ready = 1'b0;
    g0cnt = 0; g1cnt = 0; lim0 = 1000; lim1 = 1000;
    repeat (24) step();
    #1;
    chk("bp_g0cnt", g0cnt, RD);
    chk("bp_s0_ready", s0_ready, 0);
    chk("bp_m0_valid", m0_valid, 1);
    chk("bp_q0_backlog", q0.size(), RD);
    chk("bp_g1_progress", (g1cnt >= 8) ? 1 : 0, 1);
    m0_ready = 1'b1;
    for (int i = 0; i < 30 && g0cnt <= RD; i++) step();
    chk("bp_s0_reenabled", (g0cnt > RD) ? 1 : 0, 1);
    lim0 = g0cnt; lim1 = g1cnt;
    wait_drain("bp");

    // Random output backpressure on both ports.
    lim0 = g0cnt + 40; lim1 = g1cnt + 40; rnd_ready = 1'b1;
    repeat (120) step();
    rnd_ready = 1'b0; m0_ready = 1'b1; m1_ready = 1'b1;
    lim0 = g0cnt; lim1 = g1cnt;
    wait_drain("rnd");

    // Spurious adder result with nothing in flight flags a sticky error.
    repeat (LAT + 3) step();
    #1; chk("err_before", err, 0);
    inj = 1'b1;
    step();
    inj = 1'b0;
    #1;
    chk("err_set", err, 1);
    chk("err_no_m0", m0_valid, 0);
    chk("err_no_m1", m1_valid, 0);
    repeat (5) step();
    #1; chk("err_sticky", err, 1);

    // Reset with three operations in flight; stale returns must be discarded.
    g0cnt = 0; lim0 = 3; lim1 = g1cnt; en1 = 1'b0;
    for (int i = 0; i < 20 && g0cnt < 3; i++) step();
    ARESET = 1'b1;
    q0.delete(); q1.delete();
    step();
    #1;
    chk("mid_rst_s0_ready", s0_ready, 0);
    chk("mid_rst_m0_valid", m0_valid, 0);
    chk("mid_rst_add_in_valid", add_in_valid, 0);
    chk("mid_rst_err", err, 0);
    step();
    ARESET = 1'b0;
    for (int i = 0; i < LAT + 5; i++) begin
      #1;
      chk("stale_m0_valid", m0_valid, 0);
      chk("stale_m1_valid", m1_valid, 0);
      chk("stale_err", err, 0);
      step();
    end

    // After reset the first tie goes to port 0.
    en1 = 1'b1; lim0 = g0cnt + 1; lim1 = g1cnt + 1;
    step();
    #1;
    chk("tie_s0_ready", s0_ready, 1);
    chk("tie_s1_ready", s1_ready, 0);
    step();
    #1;
    chk("tie_s1_next", s1_ready, 1);
    lim1 = g1cnt + 1;
    wait_drain("tie");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
